// File: rtl/dht11_poll_scheduler.sv
// DHT11 poll scheduler: merges host and periodic requests, enforces the
// inter-read gap and per-read timeout, retries failed reads, latches good data.
module dht11_poll_scheduler #(
    parameter int unsigned MIN_GAP_CYCLES = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
    parameter int unsigned PERIOD_CYCLES  = 200_000_000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned RST_HOLD       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        auto_en,
    input  logic        host_req,
    output logic        sensor_start,
    output logic        sensor_rst_n,
    input  logic        sensor_ready,
    input  logic [15:0] sensor_data,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        fail,
    output logic [1:0]  err_code,
    output logic [1:0]  retry_cnt,
    output logic        busy
);

    localparam int unsigned CMAX =
        (TIMEOUT_CYCLES > RST_HOLD) ? TIMEOUT_CYCLES : RST_HOLD;
    localparam int GW = $clog2(MIN_GAP_CYCLES + 1);
    localparam int TW = $clog2(PERIOD_CYCLES + 1);
    localparam int CW = $clog2(CMAX + 1);

    localparam logic [GW-1:0] GAP_LOAD  = GW'(MIN_GAP_CYCLES);
    localparam logic [TW-1:0] TMR_LAST  = TW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_RSTS  = 3'd4;
    localparam logic [2:0] S_RETRY = 3'd5;
    localparam logic [2:0] S_GAPW  = 3'd6;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [GW-1:0] r_gap;
    logic [TW-1:0] r_tmr;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_sample;
    logic          r_pending;
    logic          r_ready_q;
    logic          r_start;
    logic          r_rst_n;
    logic [15:0]   r_data;
    logic          r_valid;
    logic          r_fail;
    logic [1:0]    r_err;
    logic [1:0]    r_retry;
    logic          r_busy;

    logic w_done;
    logic w_gap_zero;
    logic w_tick;
    logic w_launch;
    logic w_wait_exit;

    assign w_done      = sensor_ready & ~r_ready_q;
    assign w_gap_zero  = (r_gap == '0);
    assign w_tick      = auto_en && (r_tmr == TMR_LAST);
    assign w_launch    = (r_state == S_IDLE) && (w_next == S_START);
    assign w_wait_exit = (r_state == S_WAIT) && (w_next != S_WAIT);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (r_pending && w_gap_zero) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                // a completion edge wins over a simultaneous timeout
                if (w_done)                w_next = S_EVAL;
                else if (r_cnt == TO_LAST) w_next = S_RSTS;
            end
            S_EVAL:  w_next = (r_sample != '0) ? S_IDLE : S_RETRY;
            S_RSTS:  if (r_cnt == HOLD_LAST) w_next = S_RETRY;
            S_RETRY: w_next = (r_retry < RETRY_MAX) ? S_GAPW : S_IDLE;
            S_GAPW:  if (w_gap_zero) w_next = S_START;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_q <= 1'b0;
            r_tmr     <= '0;
            r_pending <= 1'b0;
            r_gap     <= GAP_LOAD;
        end else begin
            r_ready_q <= sensor_ready;
            if (!auto_en)    r_tmr <= '0;
            else if (w_tick) r_tmr <= '0;
            else             r_tmr <= r_tmr + TW'(1);
            if (host_req || w_tick) r_pending <= 1'b1;
            else if (w_launch)      r_pending <= 1'b0;
            if (w_wait_exit)      r_gap <= GAP_LOAD;
            else if (!w_gap_zero) r_gap <= r_gap - GW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sample <= '0;
            r_start  <= 1'b0;
            r_rst_n  <= 1'b1;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_fail   <= 1'b0;
            r_err    <= 2'b00;
            r_retry  <= 2'd0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == S_START);
            r_rst_n <= (w_next != S_RSTS);
            r_busy  <= (w_next != S_IDLE);
            r_valid <= 1'b0;
            r_fail  <= 1'b0;
            if (w_next != r_state) r_cnt <= '0;
            else if (r_state == S_WAIT || r_state == S_RSTS)
                r_cnt <= r_cnt + CW'(1);
            if (r_state == S_WAIT && w_done) r_sample <= sensor_data;
            if (w_launch) r_retry <= 2'd0;
            if (r_state == S_WAIT && w_next == S_RSTS) r_err <= 2'b10;
            if (r_state == S_EVAL) begin
                // an all-zero word is the reader's checksum-failure marker
                if (r_sample != '0) begin
                    r_data  <= r_sample;
                    r_valid <= 1'b1;
                    r_err   <= 2'b00;
                end else begin
                    r_err   <= 2'b01;
                end
            end
            if (r_state == S_RETRY) begin
                if (r_retry < RETRY_MAX) r_retry <= r_retry + 2'd1;
                else                     r_fail  <= 1'b1;
            end
        end
    end

    assign sensor_start = r_start;
    assign sensor_rst_n = r_rst_n;
    assign data_out     = r_data;
    assign data_valid   = r_valid;
    assign fail         = r_fail;
    assign err_code     = r_err;
    assign retry_cnt    = r_retry;
    assign busy         = r_busy;

endmodule
